// File: rtl/regfile_dump_reader.sv
// Debug-side register file dump engine: walks indices 0..NREGS-1 through a spare
// combinational read port and streams {index, value} beats over valid/ready.
module regfile_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ptr carries one extra bit so the last index never aliases back to 0.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  state_t        state_q;
  logic [AW:0]   ptr_q;
  logic          busy_q;
  logic          done_q;
  logic          valid_q;
  logic [AW-1:0] idx_q;
  logic [DW-1:0] data_q;
  logic          slot_free_d;

  assign slot_free_d = !valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          // Value is sampled at capture time, so late writes to higher indices show up.
          if (slot_free_d) begin
            data_q  <= rf_data;
            idx_q   <= ptr_q[AW-1:0];
            valid_q <= 1'b1;
            ptr_q   <= ptr_q + PTR_ONE;
            if (ptr_q == LAST_IDX) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rf_addr   = (state_q == S_RUN) ? ptr_q[AW-1:0] : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_data  = data_q;

endmodule
